// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates NUM_MASTERS bus masters (instruction fetch, data access, DMA...)
// onto a single slave port with a registered round-robin grant. The slave can
// insert wait states by holding PREADY low. Each transfer ends with a
// one-cycle HREADY pulse to the granted master.
//
// Transfer timing:
//   IDLE : pick a requester and latch its address, write flag and write data.
//   XFER : hold the slave bus until PREADY, then pulse HREADY and go back to
//          IDLE. A new arbitration takes place in the HREADY cycle.
//
// Optional build macro:
//   ARB_TIMEOUT_EN - abort a transfer once the slave has stalled for TIMEOUT
//                    cycles. The abort pulses HREADY and HERR together and
//                    clears HRDATA. Without it, HERR is always 0.
//
// Ports:
//   CLK     in   clock, rising edge
//   RESET   in   asynchronous reset, active low
//   HTRANS  in   [NUM_MASTERS]        request valid per master
//   HWRITE  in   [NUM_MASTERS]        write flag per master
//   HADDR   in   [NUM_MASTERS*ADDR_W] addresses, master i at [i*ADDR_W +: ADDR_W]
//   HWDATA  in   [NUM_MASTERS*DATA_W] write data, same packing
//   HRDATA  out  [DATA_W]             registered read data, shared by all masters
//   HREADY  out  [NUM_MASTERS]        one-cycle completion pulse
//   HERR    out  [NUM_MASTERS]        one-cycle error pulse, coincident with HREADY
//   stall   out  [NUM_MASTERS]        HTRANS & ~HREADY
//   PSEL    out  slave transfer active
//   PADDR   out  [ADDR_W] slave address
//   PWRITE  out  slave write enable
//   PWDATA  out  [DATA_W] slave write data
//   PRDATA  in   [DATA_W] slave read data
//   PREADY  in   slave completes the current transfer
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT     = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_MASTERS-1:0]        HTRANS,
  input  logic [NUM_MASTERS-1:0]        HWRITE,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDR,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0]             HRDATA,
  output logic [NUM_MASTERS-1:0]        HREADY,
  output logic [NUM_MASTERS-1:0]        HERR,
  output logic [NUM_MASTERS-1:0]        stall,
  output logic                          PSEL,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PWDATA,
  input  logic [DATA_W-1:0]             PRDATA,
  input  logic                          PREADY
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [GW-1:0]            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]        paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [DATA_W-1:0]        pwdata_q, pwdata_d;
  logic [DATA_W-1:0]        hrdata_q, hrdata_d;
  logic [NUM_MASTERS-1:0]   hready_q, hready_d;
  logic                     psel_q, psel_d;

  // Round-robin pick
  logic [GW-1:0]            sel;
  logic [GW-1:0]            cand;
  logic                     found;
  int                       idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0]   herr_q, herr_d;
`endif

  // Scan upward from the master after the last one served, wrapping, so the
  // most recently served master is always considered last.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx  = (int'(last_grant_q) + k) % NUM_MASTERS;
      cand = idx[GW-1:0];
      if (!found && HTRANS[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    hrdata_d     = hrdata_q;
    hready_d     = '0;
    psel_d       = psel_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    herr_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        // PREADY is not looked at here; a stray PREADY in IDLE does nothing.
        if (found) begin
          grant_d  = sel;
          paddr_d  = HADDR[sel*ADDR_W +: ADDR_W];
          pwrite_d = HWRITE[sel];
          pwdata_d = HWDATA[sel*DATA_W +: DATA_W];
          psel_d   = 1'b1;
          state_d  = XFER;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      XFER: begin
        if (PREADY) begin
          if (!pwrite_q) begin
            hrdata_d = PRDATA;
          end
          hready_d[grant_q] = 1'b1;
          last_grant_d      = grant_q;
          psel_d            = 1'b0;
          state_d           = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // A PREADY in the cycle the count hits TIMEOUT takes priority above.
        else if (cnt_q == CW'(TIMEOUT)) begin
          hready_d[grant_q] = 1'b1;
          herr_d[grant_q]   = 1'b1;
          hrdata_d          = '0;
          last_grant_d      = grant_q;
          psel_d            = 1'b0;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        psel_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      // Start as if the highest master was served last, so master 0 wins first.
      last_grant_q <= GW'(NUM_MASTERS - 1);
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      hrdata_q     <= '0;
      hready_q     <= '0;
      psel_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      herr_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      hrdata_q     <= hrdata_d;
      hready_q     <= hready_d;
      psel_q       <= psel_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      herr_q       <= herr_d;
`endif
    end
  end

  assign HRDATA = hrdata_q;
  assign HREADY = hready_q;
  assign PSEL   = psel_q;
  assign PADDR  = paddr_q;
  assign PWRITE = pwrite_q;
  assign PWDATA = pwdata_q;
  assign stall  = HTRANS & ~hready_q;

`ifdef ARB_TIMEOUT_EN
  assign HERR = herr_q;
`else
  // No abort path exists in this build, so an error can never be signalled.
  assign HERR = {NUM_MASTERS{1'b0}} & {NUM_MASTERS{TIMEOUT > 0}};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with two masters. Each scenario drives its own
// stimulus and compares against hand-computed values. Inputs change and
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 64;
  localparam int DW = 64;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic [NM-1:0]    HTRANS;
  logic [NM-1:0]    HWRITE;
  logic [NM*AW-1:0] HADDR;
  logic [NM*DW-1:0] HWDATA;
  logic [DW-1:0]    HRDATA;
  logic [NM-1:0]    HREADY;
  logic [NM-1:0]    HERR;
  logic [NM-1:0]    stall;
  logic             PSEL;
  logic [AW-1:0]    PADDR;
  logic             PWRITE;
  logic [DW-1:0]    PWDATA;
  logic [DW-1:0]    PRDATA;
  logic             PREADY;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(
    .NUM_MASTERS(NM),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .HTRANS(HTRANS),
    .HWRITE(HWRITE),
    .HADDR (HADDR),
    .HWDATA(HWDATA),
    .HRDATA(HRDATA),
    .HREADY(HREADY),
    .HERR  (HERR),
    .stall (stall),
    .PSEL  (PSEL),
    .PADDR (PADDR),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET  = 1'b0;
    HTRANS = '0;
    HWRITE = '0;
    PREADY = 1'b0;
    step();
    RESET  = 1'b1;
  endtask

  task automatic test_reset();
    RESET  = 1'b0;
    HTRANS = '0;
    HWRITE = '0;
    HADDR  = '0;
    HWDATA = '0;
    PRDATA = '0;
    PREADY = 1'b0;
    step();
    tests++; if (PSEL !== 1'b0) begin fails++; $display("FAIL reset_psel: got %0h want 0", PSEL); end
    tests++; if (HREADY !== 2'b00) begin fails++; $display("FAIL reset_hready: got %0h want 0", HREADY); end
    tests++; if (HERR !== 2'b00) begin fails++; $display("FAIL reset_herr: got %0h want 0", HERR); end
    tests++; if (HRDATA !== 64'h0) begin fails++; $display("FAIL reset_hrdata: got %0h want 0", HRDATA); end
    tests++; if (PADDR !== 64'h0 || PWRITE !== 1'b0 || PWDATA !== 64'h0) begin
      fails++; $display("FAIL reset_pbus: got addr %0h wr %0h wd %0h want 0", PADDR, PWRITE, PWDATA);
    end
    RESET = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    HADDR[0 +: AW] = 64'h100;
    HWRITE = 2'b00;
    PRDATA = 64'hDEADBEEF;
    PREADY = 1'b1;
    HTRANS = 2'b01;
    #1;
    tests++; if (stall !== 2'b01) begin fails++; $display("FAIL read_stall_req: got %0h want 1", stall); end
    step();
    tests++; if (PSEL !== 1'b1) begin fails++; $display("FAIL read_psel: got %0h want 1", PSEL); end
    tests++; if (PADDR !== 64'h100) begin fails++; $display("FAIL read_paddr: got %0h want 100", PADDR); end
    tests++; if (PWRITE !== 1'b0) begin fails++; $display("FAIL read_pwrite: got %0h want 0", PWRITE); end
    tests++; if (HREADY !== 2'b00) begin fails++; $display("FAIL read_hready_early: got %0h want 0", HREADY); end
    step();
    tests++; if (HREADY !== 2'b01) begin fails++; $display("FAIL read_hready: got %0h want 1", HREADY); end
    tests++; if (HRDATA !== 64'hDEADBEEF) begin fails++; $display("FAIL read_hrdata: got %0h want deadbeef", HRDATA); end
    tests++; if (PSEL !== 1'b0) begin fails++; $display("FAIL read_psel_done: got %0h want 0", PSEL); end
    tests++; if (stall !== 2'b00) begin fails++; $display("FAIL read_stall_done: got %0h want 0", stall); end
    tests++; if (HERR !== 2'b00) begin fails++; $display("FAIL read_herr: got %0h want 0", HERR); end
    HTRANS = 2'b00;
    step();
    tests++; if (HREADY !== 2'b00 || PSEL !== 1'b0) begin
      fails++; $display("FAIL read_idle_after: got hready %0h psel %0h want 0 0", HREADY, PSEL);
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] exp_addr;
    logic [NM-1:0] exp_rdy;
    do_reset();
    HADDR[0  +: AW] = 64'h100;
    HADDR[AW +: AW] = 64'h200;
    HWRITE = 2'b00;
    PRDATA = 64'h11;
    PREADY = 1'b1;
    HTRANS = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_addr = (t % 2 == 0) ? 64'h100 : 64'h200;
      exp_rdy  = (t % 2 == 0) ? 2'b01 : 2'b10;
      step();
      tests++; if (PSEL !== 1'b1 || PADDR !== exp_addr) begin
        fails++; $display("FAIL cont_grant%0d: got psel %0h addr %0h want 1 %0h", t, PSEL, PADDR, exp_addr);
      end
      tests++; if (stall !== 2'b11) begin fails++; $display("FAIL cont_stall_xfer%0d: got %0h want 3", t, stall); end
      step();
      tests++; if (HREADY !== exp_rdy) begin fails++; $display("FAIL cont_hready%0d: got %0h want %0h", t, HREADY, exp_rdy); end
      tests++; if (stall !== ~exp_rdy) begin fails++; $display("FAIL cont_stall%0d: got %0h want %0h", t, stall, ~exp_rdy); end
    end
    HTRANS = 2'b00;
  endtask

  task automatic test_wait_states();
    do_reset();
    HADDR[0 +: AW] = 64'h100;
    HWRITE = 2'b00;
    PRDATA = 64'hCAFE;
    PREADY = 1'b1;
    HTRANS = 2'b01;
    step();
    HTRANS = 2'b00;
    step();
    tests++; if (HRDATA !== 64'hCAFE) begin fails++; $display("FAIL wait_preread: got %0h want cafe", HRDATA); end
    HTRANS = 2'b10;
    HWRITE = 2'b10;
    HADDR[AW +: AW]  = 64'h300;
    HWDATA[DW +: DW] = 64'h55;
    PREADY = 1'b0;
    PRDATA = 64'hBAD;
    step();
    HADDR[AW +: AW]  = 64'hFFF;
    HWDATA[DW +: DW] = 64'hAA;
    for (int c = 0; c < 4; c++) begin
      tests++; if (PSEL !== 1'b1 || PADDR !== 64'h300 || PWRITE !== 1'b1 || PWDATA !== 64'h55) begin
        fails++; $display("FAIL wait_hold%0d: got psel %0h addr %0h wr %0h wd %0h want 1 300 1 55", c, PSEL, PADDR, PWRITE, PWDATA);
      end
      tests++; if (HREADY !== 2'b00) begin fails++; $display("FAIL wait_hready%0d: got %0h want 0", c, HREADY); end
      if (c < 3) step();
    end
    PREADY = 1'b1;
    step();
    tests++; if (HREADY !== 2'b10) begin fails++; $display("FAIL wait_done: got %0h want 2", HREADY); end
    tests++; if (HRDATA !== 64'hCAFE) begin fails++; $display("FAIL wait_hrdata_kept: got %0h want cafe", HRDATA); end
    tests++; if (PSEL !== 1'b0) begin fails++; $display("FAIL wait_psel_done: got %0h want 0", PSEL); end
    HTRANS = 2'b00;
    HWRITE = 2'b00;
  endtask

  task automatic test_drop_request();
    do_reset();
    HADDR[0 +: AW] = 64'h400;
    HWRITE = 2'b00;
    PREADY = 1'b0;
    HTRANS = 2'b01;
    step();
    HTRANS = 2'b00;
    #1;
    tests++; if (stall !== 2'b00) begin fails++; $display("FAIL drop_stall: got %0h want 0", stall); end
    tests++; if (PSEL !== 1'b1) begin fails++; $display("FAIL drop_psel_xfer: got %0h want 1", PSEL); end
    PRDATA = 64'h77;
    PREADY = 1'b1;
    step();
    tests++; if (HREADY !== 2'b01) begin fails++; $display("FAIL drop_hready: got %0h want 1", HREADY); end
    tests++; if (HRDATA !== 64'h77) begin fails++; $display("FAIL drop_hrdata: got %0h want 77", HRDATA); end
    // PREADY stays high while idle; it must not produce anything.
    for (int c = 0; c < 2; c++) begin
      step();
      tests++; if (PSEL !== 1'b0 || HREADY !== 2'b00) begin
        fails++; $display("FAIL drop_idle%0d: got psel %0h hready %0h want 0 0", c, PSEL, HREADY);
      end
    end
  endtask

  task automatic test_reset_mid_xfer();
    do_reset();
    HADDR[0  +: AW] = 64'h100;
    HADDR[AW +: AW] = 64'h200;
    HWRITE = 2'b00;
    PRDATA = 64'h99;
    PREADY = 1'b1;
    HTRANS = 2'b01;
    step();
    step();
    tests++; if (HRDATA !== 64'h99 || HREADY !== 2'b01) begin
      fails++; $display("FAIL rmid_pre: got hrdata %0h hready %0h want 99 1", HRDATA, HREADY);
    end
    PREADY = 1'b0;
    step();
    tests++; if (PSEL !== 1'b1) begin fails++; $display("FAIL rmid_xfer: got %0h want 1", PSEL); end
    RESET = 1'b0;
    #1;
    tests++; if (PSEL !== 1'b0 || HREADY !== 2'b00 || HRDATA !== 64'h0 || PADDR !== 64'h0) begin
      fails++; $display("FAIL rmid_clear: got psel %0h hready %0h hrdata %0h addr %0h want 0 0 0 0", PSEL, HREADY, HRDATA, PADDR);
    end
    HTRANS = 2'b11;
    step();
    RESET = 1'b1;
    step();
    tests++; if (PSEL !== 1'b1 || PADDR !== 64'h100) begin
      fails++; $display("FAIL rmid_first_grant: got psel %0h addr %0h want 1 100", PSEL, PADDR);
    end
    PREADY = 1'b1;
    step();
    tests++; if (HREADY !== 2'b01) begin fails++; $display("FAIL rmid_hready: got %0h want 1", HREADY); end
    HTRANS = 2'b00;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    HADDR[0 +: AW] = 64'h500;
    HWRITE = 2'b00;
    PRDATA = 64'h5;
    PREADY = 1'b0;
    HTRANS = 2'b01;
    step();
    HTRANS = 2'b00;
    for (int c = 0; c < TMO; c++) begin
      step();
      tests++; if (HREADY !== 2'b00) begin fails++; $display("FAIL tmo_wait%0d: got %0h want 0", c, HREADY); end
    end
    step();
    tests++; if (HREADY !== 2'b01 || HERR !== 2'b01 || HRDATA !== 64'h0 || PSEL !== 1'b0) begin
      fails++; $display("FAIL tmo_abort: got hready %0h herr %0h hrdata %0h psel %0h want 1 1 0 0", HREADY, HERR, HRDATA, PSEL);
    end
    HTRANS = 2'b01;
    step();
    HTRANS = 2'b00;
    for (int c = 0; c < TMO; c++) step();
    PREADY = 1'b1;
    step();
    tests++; if (HREADY !== 2'b01 || HERR !== 2'b00 || HRDATA !== 64'h5) begin
      fails++; $display("FAIL tmo_pready_wins: got hready %0h herr %0h hrdata %0h want 1 0 5", HREADY, HERR, HRDATA);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_wait_states();
    test_drop_request();
    test_reset_mid_xfer();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised successor to the two-master combinational memory controller: arbitrates NUM_MASTERS bus masters onto one slave port.
- Masters include instruction fetch, memory access and any future DMA.
- Registered round-robin grant, slave wait-state handshake (PREADY), per-master completion pulse and stall.
- Sits between pipeline masters and the irom/data memory inside the CPU top level.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- TIMEOUT, 16, max XFER cycles before abort (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- HTRANS  in  NUM_MASTERS  per-master request valid; bit i = master i.
- HWRITE  in  NUM_MASTERS  per-master write flag.
- HADDR  in  NUM_MASTERS*ADDR_W  flattened addresses; master i at [i*ADDR_W +: ADDR_W].
- HWDATA  in  NUM_MASTERS*DATA_W  flattened write data, same packing.
- HRDATA  out  DATA_W  registered read data, broadcast to all masters.
- HREADY  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- HERR  out  NUM_MASTERS  one-cycle error pulse, coincident with HREADY.
- stall  out  NUM_MASTERS  combinational: HTRANS[i] & ~HREADY[i].
- PSEL  out  1  slave transfer active.
- PADDR  out  ADDR_W  slave address.
- PWRITE  out  1  slave write enable.
- PWDATA  out  DATA_W  slave write data.
- PRDATA  in  DATA_W  slave read data, valid when PREADY.
- PREADY  in  1  slave completes the current transfer this cycle.

Behaviour:
- Reset (RESET=0, async): state=IDLE; PSEL, PADDR, PWRITE, PWDATA, HRDATA, HREADY, HERR all 0; last_grant=NUM_MASTERS-1, so master 0 wins first; timeout counter 0.
- FSM states are IDLE and XFER.
- IDLE:
  - If no HTRANS bit is set, stay in IDLE.
  - Otherwise select the first set bit scanning from (last_grant+1) mod NUM_MASTERS upward, wrapping.
  - Latch grant and that master's HADDR/HWRITE/HWDATA into PADDR/PWRITE/PWDATA.
  - Set PSEL=1 and go to XFER.
- XFER:
  - P* outputs are held stable; PSEL=1.
  - On PREADY=1: capture PRDATA into HRDATA when PWRITE=0 (HRDATA unchanged on writes).
  - In the same edge: pulse HREADY[grant]=1 for exactly one cycle, set last_grant=grant, PSEL=0, return to IDLE.
  - PREADY=0: remain in XFER indefinitely (no timeout unless the optional feature is enabled).
- Latency: request sampled at edge 0, PSEL high after edge 0; with PREADY=1 in the first XFER cycle, HREADY is high after edge 1. Minimum 2 cycles per transfer.
- Back-to-back: the cycle carrying HREADY is an IDLE cycle, so a new arbitration happens in it.
  - A master that keeps HTRANS high after its HREADY is re-arbitrated behind the others.
- HREADY/HERR are zero in every cycle without a completion. At most one HREADY bit is set at any time.
- HTRANS[i] dropped mid-XFER: the transfer still completes and HREADY[i] still pulses. Requests are not cancellable.
- A master's HADDR/HWDATA changing during XFER: no effect (values latched in IDLE).
- NUM_MASTERS=1: grant is always 0, no fairness logic needed.
- PREADY while in IDLE: ignored.
- Reset asserted mid-XFER: transfer abandoned, no HREADY pulse, all outputs 0 immediately.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - Counter clears on XFER entry and increments each XFER cycle with PREADY=0.
  - When it reaches TIMEOUT, next edge: HREADY[grant]=1, HERR[grant]=1, HRDATA=0, PSEL=0, last_grant=grant, back to IDLE.
  - PREADY in the same cycle the count reaches TIMEOUT wins: normal completion, HERR=0.
- Not defined: no counter; HERR is tied to 0.

Test Plan:
- Single read, N=2: HTRANS=01, HADDR0=0x100, slave PREADY=1 with PRDATA=0xDEADBEEF -> PSEL high 1 cycle with PADDR=0x100; next cycle HREADY=01, HRDATA=0xDEADBEEF, stall[0] low only in that cycle.
- Contention: HTRANS=11 held from reset, PREADY always 1 -> grant order 0,1,0,1; HREADY alternates 01,10 every 2 cycles; stall asserted on the waiting master.
- Wait states: write from master 1, HWDATA=0x55, PREADY low 3 XFER cycles -> PADDR/PWDATA/PWRITE=1 stable 4 cycles; HREADY=10 one cycle after PREADY; HRDATA unchanged.
- Drop request: HTRANS0 deasserted in the first XFER cycle -> HREADY[0] still pulses; next IDLE with HTRANS=00 stays IDLE, PSEL=0.
- Reset mid-XFER: RESET low during XFER -> PSEL/HREADY/HRDATA 0 same cycle; after release, HTRANS=11 grants master 0 first.
- ARB_TIMEOUT_EN, TIMEOUT=4, PREADY held low -> after 4 XFER cycles HREADY[g]=HERR[g]=1, HRDATA=0; PREADY=1 exactly at count 4 -> HERR=0.
